fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the Y86-64 core over a single-port, byte-wide instruction memory with 1-cycle read latency.
//  Issues one byte read per cycle and assembles icode/ifun/rA/rB/valC/valP.
//  Presents each decoded instruction to decode under a valid/ready handshake, then waits for the PC-update stage to supply the next PC.
//  Sits between the PC register / PC-update logic and the instruction memory.
// PARAMETERS
//  ADDR_LIMIT  64'd8191  highest legal byte address; any byte address above it raises imem_error
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  start          in   1   begin fetching at start_pc; honoured only in IDLE or HALTED
//  start_pc       in   64  initial PC
//  pc_next_valid  in   1   next PC available; sampled only in WAIT_PC
//  pc_next        in   64  next PC from PC-update stage
//  imem_rd_en     out  1   byte read strobe
//  imem_addr      out  64  byte address; data returns on imem_rdata in the next cycle
//  imem_rdata     in   8   read data
//  out_valid      out  1   decoded instruction fields valid
//  out_ready      in   1   decode accepts the instruction
//  icode,ifun,rA,rB  out  4 each  decoded fields
//  valC, valP     out  64  constant word (little-endian), fall-through PC
//  pc_out         out  64  PC of the presented instruction
//  halt, invalid_instr, imem_error  out  1  status, qualified by out_valid
//  busy           out  1   state != IDLE and state != HALTED
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0 except rA=rB=4'hF.
//    Reset mid-fetch abandons the fetch; the in-flight imem_rdata is ignored.
//  - States: IDLE, FETCH, PRESENT, WAIT_PC, HALTED.
//    IDLE  -start->  FETCH
//    FETCH -last byte captured or error->  PRESENT
//    PRESENT -out_valid&&out_ready->  WAIT_PC, or HALTED if halt|invalid_instr|imem_error
//    WAIT_PC -pc_next_valid->  FETCH
//    HALTED -start->  FETCH
//  - Length L by icode:
//    0,1,9 -> 1;  2,6,A,B -> 2;  3,4,5,C -> 10;  7,8 -> 9.
//    icode > 4'hC -> invalid_instr, L=1.
//  - Byte layout:
//    byte0 = {icode,ifun}.
//    For L=2 or L=10: byte1 = {rA,rB}; constant occupies bytes 2..9.
//    For L=9: constant occupies bytes 1..8.
//    valC is little-endian (first constant byte = valC[7:0]).
//    Unused fields: rA=rB=4'hF, valC=0.
//  - valP = pc_out + L, modulo 2^64.
//  - Timing: byte k is issued in cycle T+1+k, where T is the start / pc_next_valid cycle.
//    Byte0 data is decoded combinationally in its return cycle, so reads stay back-to-back.
//    out_valid rises in cycle T+2+L.
//  - Address checking happens at issue time; wrap-around of PC+k counts as out of range.
//    If a byte address > ADDR_LIMIT: no read is issued, imem_error=1, remaining fields as captured so far, and out_valid rises the next cycle.
//  - Status: halt=1 for icode 0. Priority is imem_error > invalid_instr > halt.
//  - out_valid and all fields hold stable until out_ready. out_ready while !out_valid is ignored.
//  - start while busy is ignored. pc_next_valid outside WAIT_PC is ignored.
//  - imem_rd_en=0 in IDLE, PRESENT, WAIT_PC and HALTED.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output ports
//    instr_count[31:0]  +1 on each accepted instruction
//    stall_cycles[31:0] +1 per cycle in PRESENT with !out_ready
//    Both counters saturate and clear on reset.
//  FETCH_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package y86_pkg:
//    - icode localparams (I_HALT..I_IADDQ)
//    - REG_NONE = 4'hF
//    - state encoding
//    - instr_len(icode) function
//  Sub-module fetch_len_decode: combinational icode -> {L, has_regs, has_const, invalid}.
//  Sequencer, byte counter and assembly registers live in the top module.
// TESTING
//  1. start_pc=0, mem[0]=8'h10 (nop), out_ready=1
//     -> out_valid at T+3; icode=1, valP=1, rA=rB=F; then WAIT_PC.
//  2. mem[0..9] = 30 F3 08 07 06 05 04 03 02 01 (irmovq)
//     -> rA=F, rB=3, valC=64'h0102030405060708, valP=10; out_valid at T+12.
//  3. mem[0..8] = 80 00 01 00 00 00 00 00 00 (call)
//     -> icode=8, valC=64'h100, valP=9, out_valid at T+11.
//     Hold out_ready=0 for 5 cycles -> fields stable; with FETCH_PERF_EN, stall_cycles=5.
//  4. start_pc=8185, mem[8185]=8'h30
//     -> byte 8191 is read; reading byte 8192 is refused; imem_error=1; state HALTED; imem_rd_en never asserted with addr>8191.
//  5. mem[0]=8'hE0 -> invalid_instr=1, valP=1.
//     mem[0]=8'h00 -> halt=1.
//     After acceptance: HALTED, busy=0. start from HALTED restarts the fetch.
//  6. reset asserted in cycle T+4 of test 2 -> IDLE next cycle, all outputs at reset values.
//     start issued afterwards fetches cleanly.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcode values, the empty-register code, the
// fetch sequencer state encoding and the instruction-length table.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPresent,
    StWaitPc,
    StHalted
  } fetch_state_e;

  // Unknown opcodes are treated as one-byte so fetch ends right after byte 0.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                  return 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      return 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_IADDQ: return 4'd10;
      I_JXX, I_CALL:                         return 4'd9;
      default:                               return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational icode decode: instruction length, which optional fields are
// present, and whether the opcode is defined.
module fetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       has_regs_o,
  output logic       has_const_o,
  output logic       invalid_o
);

  assign len_o       = instr_len(icode_i);
  assign has_regs_o  = (len_o == 4'd2) || (len_o == 4'd10);
  assign has_const_o = (len_o == 4'd9) || (len_o == 4'd10);
  assign invalid_o   = icode_i > I_IADDQ;

endmodule

// File: rtl/fetch_sequencer.sv
// Y86-64 byte-serial instruction fetch with valid/ready presentation to decode.
// Define FETCH_PERF_EN to add saturating instr_count / stall_cycles counters.
module fetch_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'd8191
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] start_pc,
  input  logic        pc_next_valid,
  input  logic [63:0] pc_next,
  output logic        imem_rd_en,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic        halt,
  output logic        invalid_instr,
  output logic        imem_error,
  output logic        busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_cycles
`endif
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   cnt_q, cnt_d;        // next byte index to issue
  logic         rd_pend_q, rd_pend_d;
  logic [3:0]   rd_idx_q, rd_idx_d;  // byte index of the read returning this cycle
  logic [3:0]   icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0]  valc_q, valc_d, valp_q, valp_d;
  logic         out_valid_q, out_valid_d;
  logic         halt_q, halt_d, invalid_q, invalid_d, err_q, err_d;

  logic         byte0_now;
  logic [3:0]   icode_cur, len_cur, const_idx;
  logic         has_regs_cur, has_const_cur, invalid_cur;
  logic [64:0]  issue_addr;
  logic         issue_oob, fetch_begin, enter_present, issue_err;

  // Byte 0 is decoded the cycle it returns so byte 1 can issue without a gap.
  assign byte0_now = rd_pend_q && (rd_idx_q == 4'd0);
  assign icode_cur = byte0_now ? imem_rdata[7:4] : icode_q;

  fetch_len_decode u_len_decode (
    .icode_i     (icode_cur),
    .len_o       (len_cur),
    .has_regs_o  (has_regs_cur),
    .has_const_o (has_const_cur),
    .invalid_o   (invalid_cur)
  );

  assign const_idx  = has_regs_cur ? rd_idx_q - 4'd2 : rd_idx_q - 4'd1;
  assign issue_addr = {1'b0, pc_q} + {61'd0, cnt_q};
  // A carry out of the 64-bit sum is a wrapped address and is out of range.
  assign issue_oob  = issue_addr[64] || (issue_addr[63:0] > ADDR_LIMIT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    rd_pend_d     = 1'b0;
    rd_idx_d      = rd_idx_q;
    icode_d       = icode_q;
    ifun_d        = ifun_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    valc_d        = valc_q;
    valp_d        = valp_q;
    out_valid_d   = out_valid_q;
    halt_d        = halt_q;
    invalid_d     = invalid_q;
    err_d         = err_q;
    imem_rd_en    = 1'b0;
    imem_addr     = '0;
    fetch_begin   = 1'b0;
    enter_present = 1'b0;
    issue_err     = 1'b0;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          pc_d        = start_pc;
          fetch_begin = 1'b1;
        end
      end
      StFetch: begin
        if (rd_pend_q) begin
          if (rd_idx_q == 4'd0) begin
            icode_d = imem_rdata[7:4];
            ifun_d  = imem_rdata[3:0];
          end else if (has_regs_cur && (rd_idx_q == 4'd1)) begin
            ra_d = imem_rdata[7:4];
            rb_d = imem_rdata[3:0];
          end else if (has_const_cur) begin
            for (int b = 0; b < 8; b++) begin
              if (const_idx == 4'(b)) valc_d[8*b +: 8] = imem_rdata;
            end
          end
        end
        if ((cnt_q == 4'd0) || (cnt_q < len_cur)) begin
          if (issue_oob) begin
            issue_err     = 1'b1;
            enter_present = 1'b1;
          end else begin
            imem_rd_en = 1'b1;
            imem_addr  = issue_addr[63:0];
            cnt_d      = cnt_q + 4'd1;
            rd_pend_d  = 1'b1;
            rd_idx_d   = cnt_q;
          end
        end else begin
          enter_present = 1'b1;
        end
      end
      StPresent: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (halt_q || invalid_q || err_q) ? StHalted : StWaitPc;
        end
      end
      StWaitPc: begin
        if (pc_next_valid) begin
          pc_d        = pc_next;
          fetch_begin = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fetch_begin) begin
      state_d   = StFetch;
      cnt_d     = 4'd0;
      icode_d   = 4'd0;
      ifun_d    = 4'd0;
      ra_d      = REG_NONE;
      rb_d      = REG_NONE;
      valc_d    = '0;
      valp_d    = '0;
      halt_d    = 1'b0;
      invalid_d = 1'b0;
      err_d     = 1'b0;
    end

    if (enter_present) begin
      state_d     = StPresent;
      out_valid_d = 1'b1;
      valp_d      = pc_q + 64'(len_cur);
      err_d       = issue_err;
      invalid_d   = !issue_err && invalid_cur;
      halt_d      = !issue_err && !invalid_cur && (icode_cur == I_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= '0;
      valp_q      <= '0;
      out_valid_q <= 1'b0;
      halt_q      <= 1'b0;
      invalid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      valp_q      <= valp_d;
      out_valid_q <= out_valid_d;
      halt_q      <= halt_d;
      invalid_q   <= invalid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign icode         = icode_q;
  assign ifun          = ifun_q;
  assign rA            = ra_q;
  assign rB            = rb_q;
  assign valC          = valc_q;
  assign valP          = valp_q;
  assign pc_out        = pc_q;
  assign halt          = halt_q;
  assign invalid_instr = invalid_q;
  assign imem_error    = err_q;
  assign busy          = (state_q != StIdle) && (state_q != StHalted);

`ifdef FETCH_PERF_EN
  logic [31:0] instr_count_q, instr_count_d, stall_cycles_q, stall_cycles_d;

  always_comb begin
    instr_count_d  = instr_count_q;
    stall_cycles_d = stall_cycles_q;
    if (out_valid_q && out_ready && (instr_count_q != '1)) begin
      instr_count_d = instr_count_q + 32'd1;
    end
    if ((state_q == StPresent) && !out_ready && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      instr_count_q  <= instr_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign instr_count  = instr_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed cases plus random instructions
// checked against a byte-level fetch model over an 8 KiB memory image.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, pc_next_valid, out_ready;
  logic [63:0] start_pc, pc_next;
  logic        imem_rd_en;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        out_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic        halt, invalid_instr, imem_error, busy;
`ifdef FETCH_PERF_EN
  logic [31:0] instr_count, stall_cycles;
  int          exp_instr = 0, exp_stall = 0;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_pc      (start_pc),
    .pc_next_valid (pc_next_valid),
    .pc_next       (pc_next),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .icode         (icode),
    .ifun          (ifun),
    .rA            (rA),
    .rB            (rB),
    .valC          (valC),
    .valP          (valP),
    .pc_out        (pc_out),
    .halt          (halt),
    .invalid_instr (invalid_instr),
    .imem_error    (imem_error),
    .busy          (busy)
`ifdef FETCH_PERF_EN
    ,
    .instr_count   (instr_count),
    .stall_cycles  (stall_cycles)
`endif
  );

  logic [7:0] mem [0:8191];
  int checks = 0, errors = 0, oob = 0;
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 10, 1, 1, 1};

  always @(posedge clk) begin
    imem_rdata <= (imem_rd_en && imem_addr <= 64'd8191) ? mem[imem_addr[12:0]] : 8'($urandom);
    if (imem_rd_en && imem_addr > 64'd8191) oob++;
  end

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        halt, inv, err;
    int          lat, reads;
  } exp_t;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Walk the instruction byte by byte from memory, stopping at the first illegal address.
  function automatic exp_t ref_fetch(input logic [63:0] pc);
    exp_t        e;
    int          len;
    logic [7:0]  b;
    logic [64:0] a;
    e.pc = pc; e.icode = 0; e.ifun = 0; e.ra = 4'hF; e.rb = 4'hF; e.valc = 0;
    e.err = 0; e.reads = 0;
    len = 1;
    for (int k = 0; k < len; k++) begin
      a = {1'b0, pc} + 65'(k);
      if (a[64] || a[63:0] > 64'd8191) begin
        e.err = 1;
        break;
      end
      b = mem[a[12:0]];
      e.reads = k + 1;
      if (k == 0) begin
        e.icode = b[7:4];
        e.ifun  = b[3:0];
        len     = len_tab[b[7:4]];
      end else if ((len == 2 || len == 10) && k == 1) begin
        e.ra = b[7:4];
        e.rb = b[3:0];
      end else if (len == 2 || len == 10) begin
        e.valc[8*(k-2) +: 8] = b;
      end else begin
        e.valc[8*(k-1) +: 8] = b;
      end
    end
    e.lat  = 2 + (e.err ? e.reads : len);
    e.valp = pc + 64'(len);
    e.inv  = !e.err && (e.icode > 4'hC);
    e.halt = !e.err && !e.inv && (e.icode == 4'h0);
    return e;
  endfunction

  task automatic check_fields(input exp_t e);
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("icode", 64'(icode), 64'(e.icode));
    check_eq("ifun", 64'(ifun), 64'(e.ifun));
    check_eq("rA", 64'(rA), 64'(e.ra));
    check_eq("rB", 64'(rB), 64'(e.rb));
    check_eq("valC", valC, e.valc);
    check_eq("valP", valP, e.valp);
    check_eq("pc_out", pc_out, e.pc);
    check_eq("halt", 64'(halt), 64'(e.halt));
    check_eq("invalid_instr", 64'(invalid_instr), 64'(e.inv));
    check_eq("imem_error", 64'(imem_error), 64'(e.err));
  endtask

  task automatic check_reset_state();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_rd_en", 64'(imem_rd_en), 64'd0);
    check_eq("rst_addr", imem_addr, 64'd0);
    check_eq("rst_regs", {56'd0, rA, rB}, 64'hFF);
    check_eq("rst_icode_ifun", {56'd0, icode, ifun}, 64'd0);
    check_eq("rst_valC", valC, 64'd0);
    check_eq("rst_valP_pc", valP | pc_out, 64'd0);
    check_eq("rst_status", {61'd0, halt, invalid_instr, imem_error}, 64'd0);
`ifdef FETCH_PERF_EN
    check_eq("rst_perf", {instr_count, stall_cycles}, 64'd0);
`endif
  endtask

  // One instruction: launch, wait (bounded) for out_valid, check, stall, accept.
  task automatic run_instr(input logic [63:0] pc, input bit use_start, input bit ready_early,
                           input int stall, output bit halted);
    exp_t e;
    int   n, reads, bad;
    e = ref_fetch(pc);
    @(negedge clk);
    if (use_start) begin
      start = 1'b1; start_pc = pc;
    end else begin
      pc_next_valid = 1'b1; pc_next = pc;
    end
    out_ready = ready_early;
    @(posedge clk);
    #1 start = 1'b0; pc_next_valid = 1'b0;
    n = 0; reads = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (imem_rd_en) begin
        if (imem_addr != pc + 64'(reads)) bad++;
        reads++;
      end
    end while (!out_valid && n < 40);
    check_eq("latency", 64'(n), 64'(e.lat));
    check_eq("reads", 64'(reads), 64'(e.reads));
    check_eq("read_addr_seq", 64'(bad), 64'd0);
    check_fields(e);
    if (!ready_early) begin
      repeat (stall) begin
        @(negedge clk);
        if (imem_rd_en || !out_valid) bad++;
      end
      if (stall > 0) check_fields(e);
      check_eq("hold_stable", 64'(bad), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    halted = e.halt | e.inv | e.err;
    check_eq("post_out_valid", 64'(out_valid), 64'd0);
    check_eq("post_busy", 64'(busy), 64'(!halted));
    check_eq("post_rd_en", 64'(imem_rd_en), 64'd0);
`ifdef FETCH_PERF_EN
    exp_instr++;
    exp_stall += ready_early ? 0 : stall + 1;
    check_eq("instr_count", 64'(instr_count), 64'(exp_instr));
    check_eq("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          halted;
    logic [63:0] pc;
    logic [79:0] bytes;
    reset = 1'b1; start = 1'b0; pc_next_valid = 1'b0; out_ready = 1'b0;
    start_pc = '0; pc_next = '0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();

    // pc_next_valid outside WAIT_PC must not start a fetch
    pc_next_valid = 1'b1; pc_next = 64'd4;
    @(posedge clk);
    #1 pc_next_valid = 1'b0;
    @(negedge clk);
    check_eq("pnv_ignored_busy", 64'(busy), 64'd0);
    check_eq("pnv_ignored_rd", 64'(imem_rd_en), 64'd0);

    mem[0] = 8'h10;
    run_instr(64'd0, 1'b1, 1'b1, 0, halted);

    // start while busy (WAIT_PC) is ignored
    start = 1'b1; start_pc = 64'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("start_ignored_rd", 64'(imem_rd_en), 64'd0);
    check_eq("start_ignored_busy", 64'(busy), 64'd1);

    bytes = 80'h30_F3_08_07_06_05_04_03_02_01;
    for (int i = 0; i < 10; i++) mem[i] = bytes[79 - 8*i -: 8];
    run_instr(64'd0, 1'b0, 1'b0, 2, halted);
    check_eq("irmovq_valC", valC, 64'h0102030405060708);

    bytes = 80'h80_00_01_00_00_00_00_00_00_00;
    for (int i = 0; i < 9; i++) mem[i] = bytes[79 - 8*i -: 8];
    run_instr(64'd0, 1'b0, 1'b0, 4, halted);
    check_eq("call_valC", valC, 64'h100);

    mem[8185] = 8'h30;
    run_instr(64'd8185, 1'b0, 1'b0, 1, halted);
    check_eq("limit_error", 64'(imem_error), 64'd1);

    mem[0] = 8'hE0;
    run_instr(64'd0, 1'b1, 1'b0, 0, halted);
    check_eq("invalid_flag", 64'(invalid_instr), 64'd1);
    mem[0] = 8'h00;
    run_instr(64'd0, 1'b1, 1'b0, 0, halted);
    check_eq("halt_flag", 64'(halt), 64'd1);

    // Reset in cycle T+4 of an irmovq fetch, then refetch cleanly
    bytes = 80'h30_F3_08_07_06_05_04_03_02_01;
    for (int i = 0; i < 10; i++) mem[i] = bytes[79 - 8*i -: 8];
    @(negedge clk);
    start = 1'b1; start_pc = 64'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state();
`ifdef FETCH_PERF_EN
    exp_instr = 0; exp_stall = 0;
`endif
    run_instr(64'd0, 1'b1, 1'b0, 0, halted);

    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    pc = 64'($urandom_range(8178, 8191));
        2:       pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        default: pc = 64'($urandom_range(0, 8191));
      endcase
      for (int k = 0; k < 10; k++) begin
        if (pc + 64'(k) <= 64'd8191) mem[pc[12:0] + 13'(k)] = 8'($urandom);
      end
      run_instr(pc, halted, 1'($urandom_range(0, 1)), $urandom_range(0, 3), halted);
    end

    check_eq("no_oob_reads", 64'(oob), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
